// File: rtl/mem_bank.sv
// Register-file memory bank with registered read port, write-first bypass and a
// whole-bank clear sweep. Optional per-word even parity under MEM_BANK_PARITY_EN.
module mem_bank #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clear,
    output logic [DATA_W-1:0] memory,
    output logic              rd_valid,
    output logic              busy
`ifdef MEM_BANK_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] words [DEPTH];
`ifdef MEM_BANK_PARITY_EN
    logic              par   [DEPTH];
`endif

    logic wr_ok;
    logic rd_ok;
    logic bypass;

    // A write only lands in IDLE and loses to a same-edge clear request.
    assign wr_ok  = store && !clear && (state_q == IDLE);
    assign rd_ok  = rd_en && (state_q == IDLE);
    assign bypass = wr_ok && (addr == rd_addr);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear) state_d = CLEAR;
            CLEAR:   if (idx == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    // NOTE: the storage array is reset too, since reset must leave every word at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
`ifdef MEM_BANK_PARITY_EN
                par[i]   <= 1'b0;
`endif
            end
            idx      <= '0;
            memory   <= '0;
            rd_valid <= 1'b0;
`ifdef MEM_BANK_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_ok;
`ifdef MEM_BANK_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state_q == CLEAR) begin
                // Index wraps to 0 on the last word, ready for the next sweep.
                words[idx] <= '0;
`ifdef MEM_BANK_PARITY_EN
                par[idx]   <= 1'b0;
`endif
                idx        <= idx + 1'b1;
            end else begin
                if (clear) begin
                    idx <= '0;
                end
                if (wr_ok) begin
                    words[addr] <= data;
`ifdef MEM_BANK_PARITY_EN
                    par[addr]   <= ^data;
`endif
                end
                if (rd_ok) begin
                    memory <= bypass ? data : words[rd_addr];
`ifdef MEM_BANK_PARITY_EN
                    parity_err <= bypass ? 1'b0 : (par[rd_addr] != ^words[rd_addr]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: directed scenarios plus random traffic checked
// against a countdown-based behavioural model. Define MEM_BANK_PARITY_EN for parity tests.
module tb_mem_bank;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] data  = '0;
    logic              store = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] memory;
    logic              rd_valid;
    logic              busy;
`ifdef MEM_BANK_PARITY_EN
    logic              parity_err;
`endif

    mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .store    (store),
        .addr     (addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .clear    (clear),
        .memory   (memory),
        .rd_valid (rd_valid),
        .busy     (busy)
`ifdef MEM_BANK_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: word contents, held read value, remaining sweep cycles.
    logic [DATA_W-1:0] m_word [DEPTH];
    bit                m_bad  [DEPTH];
    logic [DATA_W-1:0] m_mem;
    logic              m_valid;
    logic              m_perr;
    int                m_clear_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_word[i] = '0;
            m_bad[i]  = 1'b0;
        end
        m_mem        = '0;
        m_valid      = 1'b0;
        m_perr       = 1'b0;
        m_clear_left = 0;
    endtask

    task automatic model_edge(input bit st, input int a, input logic [DATA_W-1:0] d,
                              input bit re, input int ra, input bit cl);
        m_valid = 1'b0;
        m_perr  = 1'b0;
        if (m_clear_left > 0) begin
            m_word[DEPTH - m_clear_left] = '0;
            m_bad[DEPTH - m_clear_left]  = 1'b0;
            m_clear_left--;
        end else begin
            if (re) begin
                m_valid = 1'b1;
                if (st && !cl && a == ra) begin
                    m_mem = d;
                end else begin
                    m_mem  = m_word[ra];
                    m_perr = m_bad[ra];
                end
            end
            if (st && !cl) begin
                m_word[a] = d;
                m_bad[a]  = 1'b0;
            end
            if (cl) m_clear_left = DEPTH;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".busy"},     32'(busy),     32'(m_clear_left > 0));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
        check({tag, ".memory"},   32'(memory),   32'(m_mem));
`ifdef MEM_BANK_PARITY_EN
        check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
    task automatic step(input string tag, input bit st, input int a, input logic [DATA_W-1:0] d,
                        input bit re, input int ra, input bit cl);
        store   = st;
        addr    = ADDR_W'(a);
        data    = d;
        rd_en   = re;
        rd_addr = ADDR_W'(ra);
        clear   = cl;
        @(posedge clk);
        model_edge(st, a, d, re, ra, cl);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int busy_cycles;
        model_reset();

        // Async reset with all outputs cleared immediately.
        #1 rst_n = 1'b0;
        #1;
        check_outputs("reset");
        #10 rst_n = 1'b1;

        // Fresh bank reads back zero on every address.
        for (int i = 0; i < DEPTH; i++) step("rd_zero", 1'b0, 0, 8'h00, 1'b1, i, 1'b0);

        // Write then read on consecutive cycles.
        step("wr2", 1'b1, 2, 8'hA5, 1'b0, 0, 1'b0);
        step("wr3", 1'b1, 3, 8'h3C, 1'b0, 0, 1'b0);
        step("rd2", 1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
        check("rd2_value", 32'(memory), 32'h0000_00A5);
        step("rd3", 1'b0, 0, 8'h00, 1'b1, 3, 1'b0);
        check("rd3_value", 32'(memory), 32'h0000_003C);
        idle("hold");

        // Write-first on same address, same edge.
        step("wr_first", 1'b1, 1, 8'h77, 1'b1, 1, 1'b0);
        check("wr_first_value", 32'(memory), 32'h0000_0077);

        // Fill, then clear with a colliding store and a store mid-sweep.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, i, 8'hFF, 1'b0, 0, 1'b0);
        step("clear_go", 1'b1, 0, 8'h11, 1'b0, 0, 1'b1);
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == 1) step("sweep_store", 1'b1, 3, 8'h5A, 1'b1, 3, 1'b1);
            else        idle("sweep");
            if (busy === 1'b1) busy_cycles++;
        end
        check("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            step("rd_cleared", 1'b0, 0, 8'h00, 1'b1, i, 1'b0);
            check("rd_cleared_value", 32'(memory), 32'h0);
        end

        // Reset mid-sweep aborts it.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, i, 8'hC3, 1'b0, 0, 1'b0);
        step("clear_go2", 1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
        idle("sweep2");
        idle("sweep2");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #10 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step("rd_after_rst", 1'b0, 0, 8'h00, 1'b1, i, 1'b0);
        step("wr_after_rst", 1'b1, 0, 8'h42, 1'b1, 0, 1'b0);

`ifdef MEM_BANK_PARITY_EN
        // Corrupt the stored parity of word 1 and confirm only that read flags it.
        step("par_wr1", 1'b1, 1, 8'h01, 1'b0, 0, 1'b0);
        step("par_wr2", 1'b1, 2, 8'h03, 1'b0, 0, 1'b0);
        dut.par[1] = ~dut.par[1];
        m_bad[1] = 1'b1;
        step("par_rd1", 1'b0, 0, 8'h00, 1'b1, 1, 1'b0);
        check("par_err1", 32'(parity_err), 32'h1);
        step("par_rd2", 1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
        check("par_err2", 32'(parity_err), 32'h0);
        step("par_fix1", 1'b1, 1, 8'h01, 1'b0, 0, 1'b0);
`endif

        // Random traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 DATA_W'($urandom), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
